// File: rtl/parity_pkg.sv
// Shared definitions for the parity checker and generator models:
// FSM state encoding, parity mode constants and the transmitted-bit rule.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  // Widest frame any checker/generator variant supports.
  localparam int MAX_DATA_W = 16;

  // Transmitted parity bit for a word (zero-extended to MAX_DATA_W).
  // Odd mode sends the plain XOR, even mode sends its inverse.
  function automatic logic expected_parity(input logic [MAX_DATA_W-1:0] data,
                                           input logic                  odd_sel);
    return (odd_sel == PARITY_ODD) ? ^data : ~(^data);
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a DATA_W-bit word with odd/even mode select.
// Output is the bit a matching generator would transmit for this word.
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd_sel,
  output logic              parity
);

  // XOR-reduce the word, invert for even mode
  always_comb begin
    parity = ^data;
    if (odd_sel != PARITY_ODD) parity = ~parity;
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Receive-side parity frame checker. Deserialises DATA_W data bits (LSB
// first) plus one parity bit, then reports the word with a one-cycle
// data_valid pulse and a parity error flag.
// Optional: define PARITY_ERR_CNT_EN to add the saturating err_count port.
//
// state  | meaning
// IDLE   | waiting for start
// DATA   | accepting data bits, cnt = bits received so far
// PARITY | waiting for the parity bit
// DONE   | one-cycle result cycle, data_valid high
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              odd_sel,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              mode_q;
  logic              exp_par;
  logic              data_accept;
  logic              par_accept;
  logic              last_bit;

  parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .data    (shift_q),
    .odd_sel (mode_q),
    .parity  (exp_par)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and bit-acceptance strobes; start overrides everything,
  // including a bit presented in the same cycle
  always_comb begin
    state_d     = state_q;
    data_accept = 1'b0;
    par_accept  = 1'b0;
    last_bit    = (cnt_q == CNT_W'(DATA_W - 1));
    busy        = (state_q == DATA) || (state_q == PARITY);
    if (start) begin
      state_d = DATA;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        DATA: begin
          if (bit_valid) begin
            data_accept = 1'b1;
            if (last_bit) state_d = PARITY;
          end
        end
        PARITY: begin
          if (bit_valid) begin
            par_accept = 1'b1;
            state_d    = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Place the incoming bit at position cnt
  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_accept && (cnt_q == CNT_W'(i))) shift_d[i] = bit_in;
    end
  end

  // Frame datapath; results are registered on the parity edge so they
  // appear together with data_valid during DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      mode_q     <= PARITY_EVEN;
      data_out   <= '0;
      parity_err <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= par_accept;
      if (start) begin
        mode_q  <= odd_sel;
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (data_accept) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (par_accept) begin
        data_out   <= shift_q;
        parity_err <= (bit_in != exp_par);
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Saturating count of reported frames with a parity error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (data_valid && parity_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker: directed frames from the
// test plan, then randomized frames with aborts and gaps, all checked
// against a queue-based frame model. err_count checks need PARITY_ERR_CNT_EN.
module tb_parity_frame_checker;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          odd_sel = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          busy;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } frame_t;

  frame_t exp_q[$];
  int     valid_cyc[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     model_err_cnt = 0;
  logic   prev_dv = 1'b0;

  parity_frame_checker #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .odd_sel    (odd_sel),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .busy       (busy)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: count the ones; odd mode transmits 1 for an odd count,
  // even mode transmits the opposite.
  function automatic logic model_err(input logic [DW-1:0] d, input logic par, input logic odd);
    int   ones;
    logic tx;
    ones = $countones(d);
    tx   = ((ones % 2) == 1);
    if (!odd) tx = !tx;
    return par != tx;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick(input logic s, input logic bv, input logic b, input logic o);
    @(negedge clk);
    start     = s;
    bit_valid = bv;
    bit_in    = b;
    odd_sel   = o;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, rbit(), rbit());
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, max_gap));
      tick(1'b0, 1'b1, bits[i], rbit());
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic odd,
                            input int max_gap);
    frame_t f;
    tick(1'b1, rbit(), rbit(), odd);
    send_bits(16'(d), DW, max_gap);
    idle($urandom_range(0, max_gap));
    tick(1'b0, 1'b1, par, rbit());
    f.data = d;
    f.err  = model_err(d, par, odd);
    exp_q.push_back(f);
  endtask

  task automatic drain();
    int k;
    k = 0;
    idle(1);
    while (exp_q.size() != 0 && k < 20) begin
      idle(1);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: every data_valid must match the oldest expected frame
  initial begin
    frame_t f;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_dv = 1'b0;
      end else begin
        if (data_valid) begin
          check("dv_one_cycle", 32'(prev_dv), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
          end else begin
            f = exp_q.pop_front();
            check("data", 32'(data_out), 32'(f.data));
            check("perr", 32'(parity_err), 32'(f.err));
            if (f.err && model_err_cnt < 255) model_err_cnt++;
          end
          valid_cyc.push_back(cyc);
        end
        prev_dv = data_valid;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic          odd;
    logic          par;
    int            nv;

    // Reset state
    idle(2);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_count", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Odd mode 1101, parity 1
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    #1 check("busy_in_data", 32'(busy), 32'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back('{4'hD, 1'b0});
    drain();
    check("odd_data", 32'(data_out), 32'hD);
    check("odd_perr", 32'(parity_err), 32'd0);

    // Even mode 1101, parity 1 -> error
`ifdef PARITY_ERR_CNT_EN
    check("cnt_before", 32'(err_count), 32'd0);
`endif
    send_frame(4'hD, 1'b1, 1'b0, 0);
    drain();
    idle(5);
    check("hold_data", 32'(data_out), 32'hD);
    check("hold_perr", 32'(parity_err), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("cnt_after", 32'(err_count), 32'd1);
`endif

    // Gaps and abort: two odd-mode bits with 3-cycle gaps, then a restart
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      idle(3);
      tick(1'b0, 1'b1, 1'b1, rbit());
    end
    idle(3);
    send_frame(4'h0, 1'b0, 1'b1, 0);
    drain();
    check("abort_data", 32'(data_out), 32'd0);
    check("abort_perr", 32'(parity_err), 32'd0);

    // Back-to-back frames: start in DONE cycle of the first
    send_frame(4'hA, 1'b1, 1'b1, 0);
    send_frame(4'h5, 1'b1, 1'b0, 0);
    drain();
    nv = valid_cyc.size();
    if (nv >= 2) check("b2b_spacing", 32'(valid_cyc[nv-1] - valid_cyc[nv-2]), 32'd6);
    else check("b2b_count", 32'(nv), 32'd2);

    // Reset after the parity bit is presented, before the result cycle
    send_frame(4'hD, 1'b1, 1'b1, 0);
    drain();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'h0007, DW, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_err_cnt = 0;
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_valid", 32'(data_valid), 32'd0);
    check("arst_perr", 32'(parity_err), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("arst_err_count", 32'(err_count), 32'd0);
`endif
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    check("post_rst_data", 32'(data_out), 32'd0);

    // Randomized frames with occasional aborts and idle gaps
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        tick(1'b1, rbit(), rbit(), rbit());
        send_bits(16'($urandom), $urandom_range(0, DW), 2);
      end
      d   = DW'($urandom);
      odd = rbit();
      par = rbit();
      send_frame(d, par, odd, 2);
      idle($urandom_range(0, 2));
    end
    drain();
`ifdef PARITY_ERR_CNT_EN
    check("rand_err_count", 32'(err_count), 32'(model_err_cnt));

    // Saturation: 300 erroneous frames
    for (int n = 0; n < 300; n++) begin
      d   = DW'($urandom);
      odd = rbit();
      par = !model_err(d, 1'b0, odd);
      send_frame(d, par, odd, 0);
    end
    drain();
    idle(2);
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_model", 32'(err_count), 32'(model_err_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
